maindec_fsm: RTL and testbench

Multicycle main control unit for the 8-bit microprocessor. It sequences each instruction through fetch, decode, execute and writeback or branch, and performs the instruction-memory fetch handshake. It drives `aluop`/`funct` to the ALU decoder, which sits beside it in the top level. It also generates the register-file, instruction-register and PC write strobes, and keeps a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/maindec_fsm.sv | 111 +++++++++++
 tb/tb_maindec_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared control constants for the 8-bit microprocessor
// Purpose: state encodings, opcode and branch-funct constants used by the
//          main control FSM and the ALU decoder.
// Ports:   none (package).
package cpu_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_BRANCH = 3'd5;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_ADDI  = 2'b01;
    localparam logic [1:0] OP_SUBI  = 2'b10;
    localparam logic [1:0] OP_RTYPE = 2'b11;

    localparam logic [1:0] BR_ZF = 2'b00;
    localparam logic [1:0] BR_ZB = 2'b01;
    localparam logic [1:0] BR_F  = 2'b10;
    localparam logic [1:0] BR_B  = 2'b11;

    // Conditional branch kinds wait on the zero flag; the rest always take.
    function automatic logic br_is_conditional(input logic [1:0] f);
        return (f == BR_ZF) || (f == BR_ZB);
    endfunction

endpackage

// File: rtl/maindec_fsm.sv
// rtl/maindec_fsm.sv - multicycle main control FSM with fetch handshake
// Purpose: sequences IDLE -> FETCH -> DECODE -> EXEC -> WB/BRANCH -> FETCH,
//          drives ALU decoder inputs, write strobes and a retired counter.
// Ports:   clk, reset_n (async active-low)
//          instr[7:0], mem_ready, zero                 - inputs
//          mem_req, irwrite, pcinc, pcwrite, regwrite  - strobes
//          aluop[1:0], funct[1:0]                      - to ALU decoder
//          state[2:0], instret[INSTRET_W-1:0]          - debug / counter
module maindec_fsm
    import cpu_pkg::*;
#(
    parameter int INSTRET_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           instr,
    input  logic                 mem_ready,
    input  logic                 zero,
    output logic                 mem_req,
    output logic                 irwrite,
    output logic                 pcinc,
    output logic                 pcwrite,
    output logic                 regwrite,
    output logic [1:0]           aluop,
    output logic [1:0]           funct,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [1:0]           r_op_q;
    logic [1:0]           r_funct_q;
    logic [INSTRET_W-1:0] r_instret;

    // State register plus the DECODE-time instruction latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_op_q    <= OP_PASS;
            r_funct_q <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_op_q    <= instr[7:6];
                r_funct_q <= instr[5:4];
            end
        end
    end

    // Retirement happens on leaving WB or BRANCH, taken or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instret <= '0;
        end else if (r_state == ST_WB || r_state == ST_BRANCH) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    // Next-state logic; encodings 6 and 7 recover to IDLE.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: w_next_state = ST_EXEC;
            ST_EXEC:   w_next_state = (r_op_q == OP_RTYPE) ? ST_BRANCH : ST_WB;
            ST_WB:     w_next_state = ST_FETCH;
            ST_BRANCH: w_next_state = ST_FETCH;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output logic; IDLE (and thus reset) drives every strobe low.
    always_comb begin
        mem_req  = 1'b0;
        irwrite  = 1'b0;
        pcinc    = 1'b0;
        pcwrite  = 1'b0;
        regwrite = 1'b0;
        aluop    = OP_PASS;
        funct    = 2'b00;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                irwrite = mem_ready;
                pcinc   = mem_ready;
            end
            ST_EXEC: begin
                aluop = r_op_q;
                funct = r_funct_q;
            end
            ST_WB: begin
                aluop    = r_op_q;
                funct    = r_funct_q;
                regwrite = 1'b1;
            end
            ST_BRANCH: begin
                aluop   = r_op_q;
                funct   = r_funct_q;
                pcwrite = br_is_conditional(r_funct_q) ? zero : 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_maindec_fsm.sv
// tb/tb_maindec_fsm.sv - directed self-checking bench for maindec_fsm
module tb_maindec_fsm;

    logic       clk;
    logic       reset_n;
    logic [7:0] instr;
    logic       mem_ready;
    logic       zero;
    logic       mem_req;
    logic       irwrite;
    logic       pcinc;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] aluop;
    logic [1:0] funct;
    logic [2:0] state;
    logic [7:0] instret;

    int checks = 0;
    int errors = 0;

    maindec_fsm #(.INSTRET_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .zero      (zero),
        .mem_req   (mem_req),
        .irwrite   (irwrite),
        .pcinc     (pcinc),
        .pcwrite   (pcwrite),
        .regwrite  (regwrite),
        .aluop     (aluop),
        .funct     (funct),
        .state     (state),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample at the falling edge; also check the
    // strobe exclusivity rules in every cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("pcinc_pcwrite_excl", {31'd0, pcinc & pcwrite}, 32'd0);
        check("regwrite_pcwrite_excl", {31'd0, regwrite & pcwrite}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {23'd0, mem_req, irwrite, pcinc, pcwrite, regwrite, aluop, funct}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        instr     = 8'b01_00_0011;
        mem_ready = 1'b1;
        zero      = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_instret", {24'd0, instret}, 32'd0);
        check_all_zero("reset_outputs");

        // Reset then ADDI: 0,1,2,3,4,1
        reset_n = 1'b1;
        #1;
        check("rel_idle", {29'd0, state}, 32'd0);
        step();
        check("addi_fetch", {29'd0, state}, 32'd1);
        check("addi_fetch_strobes", {29'd0, mem_req, irwrite, pcinc}, 32'b111);
        step();
        check("addi_decode", {29'd0, state}, 32'd2);
        check("addi_decode_alu", {28'd0, aluop, funct}, 32'd0);
        step();
        check("addi_exec", {29'd0, state}, 32'd3);
        check("addi_exec_aluop", {30'd0, aluop}, 32'b01);
        check("addi_exec_regwrite", {31'd0, regwrite}, 32'd0);
        step();
        check("addi_wb", {29'd0, state}, 32'd4);
        check("addi_wb_aluop", {30'd0, aluop}, 32'b01);
        check("addi_wb_regwrite", {31'd0, regwrite}, 32'd1);
        mem_ready = 1'b0;
        instr     = 8'b11_00_0010;
        step();
        check("addi_back_fetch", {29'd0, state}, 32'd1);
        check("addi_instret", {24'd0, instret}, 32'd1);

        // Fetch stall: three cycles with mem_ready low
        for (int i = 0; i < 3; i++) begin
            check("stall_state", {29'd0, state}, 32'd1);
            check("stall_strobes", {29'd0, mem_req, irwrite, pcinc}, 32'b100);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("stall_release", {29'd0, mem_req, irwrite, pcinc}, 32'b111);
        step();
        check("stall_decode", {29'd0, state}, 32'd2);
        check("stall_decode_strobes", {30'd0, irwrite, pcinc}, 32'd0);

        // Conditional branch, zero=1 in BRANCH (zero=0 in EXEC)
        step();
        check("bz1_exec", {28'd0, aluop, funct}, 32'b1100);
        step();
        zero = 1'b1;
        #1;
        check("bz1_branch", {29'd0, state}, 32'd5);
        check("bz1_pcwrite", {31'd0, pcwrite}, 32'd1);
        check("bz1_funct", {30'd0, funct}, 32'b00);
        check("bz1_regwrite", {31'd0, regwrite}, 32'd0);
        step();
        check("bz1_instret", {24'd0, instret}, 32'd2);

        // Same branch, zero=1 only in EXEC, zero=0 in BRANCH: not taken
        step();
        step();
        zero = 1'b1;
        check("bz0_exec", {29'd0, state}, 32'd3);
        step();
        zero = 1'b0;
        #1;
        check("bz0_pcwrite", {31'd0, pcwrite}, 32'd0);
        instr = 8'b11_11_0001;
        step();
        check("bz0_instret", {24'd0, instret}, 32'd3);

        // Unconditional backward branch with zero=0
        step();
        step();
        check("ub_exec", {28'd0, aluop, funct}, 32'b1111);
        step();
        check("ub_branch", {29'd0, state}, 32'd5);
        check("ub_alu", {28'd0, aluop, funct}, 32'b1111);
        check("ub_pcwrite", {31'd0, pcwrite}, 32'd1);
        check("ub_regwrite", {31'd0, regwrite}, 32'd0);
        instr = 8'b10_10_0101;
        step();
        check("ub_instret", {24'd0, instret}, 32'd4);

        // Mid-instruction reset in EXEC of SUBI
        step();
        step();
        check("subi_exec", {28'd0, aluop, funct}, 32'b1010);
        reset_n = 1'b0;
        #1;
        check("midrst_state", {29'd0, state}, 32'd0);
        check_all_zero("midrst_outputs");
        check("midrst_instret", {24'd0, instret}, 32'd0);
        step();
        check("midrst_hold", {29'd0, state}, 32'd0);
        reset_n = 1'b1;
        instr   = 8'b00_00_0000;
        #1;
        check("midrst_rel_idle", {29'd0, state}, 32'd0);
        step();
        check("midrst_fetch", {29'd0, state}, 32'd1);

        // Counter wrap: 256 PASS instructions
        for (int n = 0; n < 255; n++) begin
            repeat (4) step();
        end
        check("wrap_255", {24'd0, instret}, 32'd255);
        repeat (3) step();
        check("wrap_wb", {29'd0, state}, 32'd4);
        check("wrap_wb_instret", {24'd0, instret}, 32'd255);
        step();
        check("wrap_0", {24'd0, instret}, 32'd0);
        check("wrap_fetch", {29'd0, state}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
